fp4_e2m1_block_quantizer: RTL and testbench

- Converts signed fixed-point accumulator results (MAC output domain) back into FP4 E2M1 codes using one shared power-of-two scale per block (MX-style).
- Sits at the MAC array output and produces the next layer's FP4 weight/activation stream.
- Buffers one block, finds the max magnitude, derives the shared exponent, then streams the encoded elements out under valid/ready.

---
 rtl/fp4_e2m1_block_quantizer_if.sv | 25 ++
 rtl/fp4_e2m1_block_quantizer.sv | 139 +++++++++++++
 tb/tb_fp4_e2m1_block_quantizer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp4_e2m1_block_quantizer_if.sv
// Handshake bundle for the FP4 E2M1 block quantizer: accumulator input stream
// and encoded FP4 output stream with shared scale.
interface fp4_e2m1_block_quantizer_if #(
  parameter int unsigned AccWidth   = 18,
  parameter int unsigned ScaleWidth = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [AccWidth-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_data;
  logic [ScaleWidth-1:0] out_scale;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_scale, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_scale, out_last
  );
endinterface

// File: rtl/fp4_e2m1_block_quantizer.sv
// Buffers a block of signed accumulator words, derives a shared power-of-two scale
// from the block max magnitude, then streams E2M1 codes out under valid/ready.
module fp4_e2m1_block_quantizer #(
  parameter int unsigned AccWidth   = 18,
  parameter int unsigned BlockSize  = 8,
  parameter int unsigned ScaleWidth = 8
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  fp4_e2m1_block_quantizer_if.slave bus_io
);
  localparam int unsigned IdxW = (BlockSize > 1) ? $clog2(BlockSize) : 1;
  localparam int unsigned PosW = $clog2(AccWidth);
  localparam int unsigned ExtW = AccWidth + 4;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BlockSize - 1);
  // Rounding thresholds between adjacent grid points, in units of 0.25.
  localparam logic [4:0] Mid [7] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd10, 5'd14, 5'd20};

  if (BlockSize < 2) begin : g_bad_block
    $error("BlockSize must be at least 2");
  end
  if (ScaleWidth < 2 || (AccWidth - 3) >= (1 << (ScaleWidth - 1))) begin : g_bad_scale
    $error("ScaleWidth too narrow for shared exponent range");
  end

  typedef enum logic [1:0] {StFill, StScale, StDrain} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       wr_idx_q, rd_idx_q;
  logic [AccWidth-1:0]   amax_q;
  logic [PosW-1:0]       pos_q;
  logic                  in_ready_q, out_valid_q, out_last_q;
  logic [3:0]            out_data_q;
  logic [ScaleWidth-1:0] out_scale_q;
  logic [AccWidth-1:0]   buf_q [BlockSize];

  logic                  accept;
  logic [AccWidth-1:0]   in_mag, rd_elem, rd_mag;
  logic [PosW-1:0]       amax_pos;
  logic [ScaleWidth-1:0] scale_d;
  logic [ExtW-1:0]       ext, ext_mask;
  logic [4:0]            quarters;
  logic                  sticky;
  logic [2:0]            mag_code;
  logic [3:0]            enc_code;

  assign accept = (state_q == StFill) && bus_io.in_valid && in_ready_q;

  always_comb begin
    in_mag = bus_io.in_data[AccWidth-1] ? -bus_io.in_data : bus_io.in_data;
    amax_pos = '0;
    for (int unsigned i = 0; i < AccWidth; i++) begin
      if (amax_q[i]) amax_pos = PosW'(i);
    end
    scale_d = (amax_q == '0) ? '0 : ScaleWidth'(amax_pos) - ScaleWidth'(2);
  end

  // quarters = |x| * 2^(4-p) truncated; sticky keeps the bits shifted out.
  always_comb begin
    rd_elem  = buf_q[rd_idx_q];
    rd_mag   = rd_elem[AccWidth-1] ? -rd_elem : rd_elem;
    ext      = {rd_mag, 4'b0000};
    ext_mask = ~({ExtW{1'b1}} << pos_q);
    sticky   = |(ext & ext_mask);
    quarters = 5'(ext >> pos_q);
    mag_code = '0;
    for (int i = 0; i < 7; i++) begin
      // Exact ties move up only when the lower code has man=1.
      if ((quarters > Mid[i]) || ((quarters == Mid[i]) && (sticky || (i % 2 == 1)))) begin
        mag_code = mag_code + 3'd1;
      end
    end
    enc_code = {rd_elem[AccWidth-1] && (mag_code != 3'd0), mag_code};
  end

  always_ff @(posedge clk_i) begin
    if (accept) buf_q[wr_idx_q] <= bus_io.in_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StFill;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      amax_q      <= '0;
      pos_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_scale_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (in_mag > amax_q) amax_q <= in_mag;
            if (wr_idx_q == LastIdx) begin
              wr_idx_q   <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StScale;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        StScale: begin
          pos_q       <= amax_pos;
          out_scale_q <= scale_d;
          amax_q      <= '0;
          rd_idx_q    <= '0;
          state_q     <= StDrain;
        end
        StDrain: begin
          if (!out_valid_q || bus_io.out_ready) begin
            if (out_valid_q && out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StFill;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= enc_code;
              out_last_q  <= (rd_idx_q == LastIdx);
              rd_idx_q    <= (rd_idx_q == LastIdx) ? '0 : rd_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_scale = out_scale_q;
  assign bus_io.out_last  = out_last_q;
endmodule

// File: tb/tb_fp4_e2m1_block_quantizer.sv
// Randomized self-checking bench: real-valued nearest-grid model feeds an expected queue
// that one monitor compares against the DUT on every valid output cycle.
module tb_fp4_e2m1_block_quantizer;
  localparam int unsigned AccW = 18;
  localparam int unsigned BlkN = 8;
  localparam int unsigned ScW  = 8;

  typedef struct packed {
    logic [3:0]     code;
    logic [ScW-1:0] scale;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_cnt  = 0;
  bit   rand_ready = 1'b0;
  bit   chk_ready_next = 1'b0;
  exp_t exp_q [$];

  logic signed [AccW-1:0] blk [BlkN];
  logic [3:0] pin_codes [BlkN];
  int         pin_scale;
  bit         pin_en = 1'b0;
  int         gq [8] = '{0, 2, 4, 6, 8, 12, 16, 24};

  fp4_e2m1_block_quantizer_if #(.AccWidth(AccW), .ScaleWidth(ScW)) bus ();

  fp4_e2m1_block_quantizer #(
    .AccWidth  (AccW),
    .BlockSize (BlkN),
    .ScaleWidth(ScW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int floor_log2(input int v);
    int p = 0;
    while ((2 ** (p + 1)) <= v) p++;
    return p;
  endfunction

  function automatic int model_scale(input int amax);
    if (amax == 0) return 0;
    return floor_log2(amax) - 2;
  endfunction

  // Nearest grid point in real arithmetic; on an exact tie the even grid index wins.
  function automatic int model_code(input int x, input int amax);
    int  p, mag, best;
    real sq, d, bestd;
    if (amax == 0) return 0;
    p     = floor_log2(amax);
    mag   = (x < 0) ? -x : x;
    sq    = real'(mag) * 16.0 / real'(2 ** p);
    best  = 0;
    bestd = 1.0e9;
    for (int i = 0; i < 8; i++) begin
      d = sq - real'(gq[i]);
      if (d < 0.0) d = -d;
      if ((d < bestd) || ((d == bestd) && (i % 2 == 0))) begin
        best  = i;
        bestd = d;
      end
    end
    return ((x < 0) && (best != 0)) ? best + 8 : best;
  endfunction

  // Called in the phase just after a rising edge.
  task automatic send_block();
    int   amax, x, code, scale, cnt;
    bit   acc;
    exp_t e;
    amax = 0;
    for (int i = 0; i < BlkN; i++) begin
      x = int'(blk[i]);
      if (x < 0) x = -x;
      if (x > amax) amax = x;
    end
    scale = model_scale(amax);
    if (pin_en) check("model_pin_scale", 32'(scale), 32'(pin_scale));
    for (int i = 0; i < BlkN; i++) begin
      code = model_code(int'(blk[i]), amax);
      if (pin_en) check("model_pin_code", 32'(code), 32'(pin_codes[i]));
      e.code  = 4'(code);
      e.scale = ScW'(scale);
      e.last  = (i == BlkN - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < BlkN; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = blk[i];
      acc = 1'b0;
      cnt = 0;
      while (!acc) begin
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        cnt++;
        if (!acc && cnt > 2000) begin
          n_fail++;
          $display("FAIL in_ready_timeout: in_ready=%0b, expected 1 within 2000 cycles",
                   bus.in_ready);
          $fatal(1, "stopping: input never accepted");
        end
      end
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_hs(input int target);
    int cnt = 0;
    while (hs_cnt < target && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("handshake_timeout", 32'(hs_cnt >= target), 32'd1);
  endtask

  task automatic wait_drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic gen_random_block();
    int unsigned     mode, k, sh;
    int              v;
    logic [AccW-1:0] r;
    mode = $urandom_range(0, 4);
    k    = $urandom_range(0, 17);
    sh   = $urandom_range(0, 12);
    for (int i = 0; i < BlkN; i++) begin
      r = AccW'($urandom);
      case (mode)
        0: v = int'($signed(r));
        1: v = int'($urandom_range(0, (1 << k) - 1));
        2: v = int'($urandom_range(0, 1));
        3: v = int'($urandom_range(0, 31)) << sh;
        default: v = 0;
      endcase
      if (mode != 0 && $urandom_range(0, 1) == 1) v = -v;
      blk[i] = AccW'(v);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (chk_ready_next) begin
          check("in_ready_after_last", 32'(bus.in_ready), 32'd1);
          chk_ready_next = 1'b0;
        end
        if (bus.out_valid) begin
          check("in_ready_in_drain", 32'(bus.in_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            e = exp_q[0];
            check("out_data", 32'(bus.out_data), 32'(e.code));
            check("out_scale", 32'(bus.out_scale), 32'(e.scale));
            check("out_last", 32'(bus.out_last), 32'(e.last));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
              if (e.last) chk_ready_next = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    int base;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_scale", 32'(bus.out_scale), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rand_ready = 1'b1;
    pin_en     = 1'b1;

    blk       = '{18'sd96, -18'sd48, 18'sd24, 18'sd0, 18'sd12, 18'sd6, 18'sd3, -18'sd96};
    pin_codes = '{4'b0111, 4'b1101, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b1111};
    pin_scale = 4;
    send_block();
    @(negedge clk);
    check("latency_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle3", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    blk       = '{18'sd7, 18'sd5, -18'sd5, 18'sd1, 18'sd0, 18'sd0, 18'sd0, 18'sd0};
    pin_codes = '{4'b0111, 4'b0110, 4'b1110, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    pin_scale = 0;
    send_block();

    blk       = '{18'h20000, 18'sd1, 18'sd1, 18'sd1, 18'sd1, 18'sd1, 18'sd1, 18'sd1};
    pin_codes = '{4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    pin_scale = 15;
    send_block();

    blk       = '{18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0};
    pin_codes = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    pin_scale = 0;
    send_block();
    pin_en = 1'b0;

    repeat (40) begin
      gen_random_block();
      send_block();
    end
    wait_drain();

    // Consumer stall on element 3.
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    base = hs_cnt;
    blk  = '{18'sd7, 18'sd5, -18'sd5, 18'sd1, -18'sd3, 18'sd2, 18'sd0, -18'sd6};
    send_block();
    wait_hs(base + 3);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset mid-drain, then a fresh small block.
    base = hs_cnt;
    blk  = '{18'sd96, -18'sd48, 18'sd24, 18'sd0, 18'sd12, 18'sd6, 18'sd3, -18'sd96};
    send_block();
    wait_hs(base + 3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("async_rst_out_last", 32'(bus.out_last), 32'd0);
    exp_q.delete();
    chk_ready_next = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rerelease", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rand_ready = 1'b1;
    pin_en     = 1'b1;
    blk        = '{18'sd3, -18'sd2, 18'sd1, 18'sd0, 18'sd0, 18'sd0, 18'sd1, 18'sd0};
    pin_codes  = '{4'b0111, 4'b1110, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    pin_scale  = -1;
    send_block();
    pin_en = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
